// File: rtl/karin_hs_pkg.sv
// Shared types and defaults for the Karin 2-phase req/fin bridges.
package karin_hs_pkg;

    localparam int unsigned KARIN_WIDTH       = 32;
    localparam int unsigned KARIN_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StWaitFin,
        StSettle,
        StDone,
        StAbandon
    } karin_state_e;

endpackage

// File: rtl/karin_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit, synchronously reset to 0.
module karin_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_req_master.sv
// Clocked initiator for the Karin 2-phase bundled-data handshake: launches an operand
// toward a self-timed block, waits for fin, and returns the captured result.
module async_req_master
    import karin_hs_pkg::*;
#(
    parameter int unsigned WIDTH       = KARIN_WIDTH,
    parameter int unsigned SYNC_STAGES = KARIN_SYNC_STAGES,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned SETTLE_CYC  = 1,
    parameter int unsigned TIMEOUT     = 65535,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_timeout,
    output logic             busy,
    output logic             req_o,
    input  logic             fin_i,
    output logic [WIDTH-1:0] n_o,
    input  logic [WIDTH-1:0] result_i
);

    localparam logic [CNT_W-1:0] SetupLast   = CNT_W'((SETUP_CYC == 0) ? 0 : SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] SettleLast  = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit               TimeoutEn   = (TIMEOUT != 0);

    karin_state_e         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                 req_q, req_d;
    logic [WIDTH-1:0]     n_q, n_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_result_q, out_result_d;
    logic                 out_timeout_q, out_timeout_d;
    logic [SYNC_STAGES-1:0] flush_q, flush_d;
    logic                 fin_s;
    logic                 phase_match;
    logic                 flush_done;
    logic                 in_ready_w;

    karin_sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_fin_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (fin_i),
        .q_o  (fin_s)
    );

    // The synchroniser holds 0 through reset; block acceptance until it carries real fin_i.
    assign flush_d     = {flush_q[SYNC_STAGES-2:0], 1'b1};
    assign flush_done  = flush_q[SYNC_STAGES-1];
    assign phase_match = (fin_s == req_q);
    assign in_ready_w  = (state_q == StIdle) && phase_match && flush_done;
    assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_d         = req_q;
        n_d           = n_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_timeout_d = out_timeout_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_w) begin
                    n_d     = in_n;
                    cnt_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    req_d   = ~req_q;
                    cnt_d   = '0;
                    state_d = StWaitFin;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StWaitFin: begin
                if (phase_match) begin
                    cnt_d   = '0;
                    state_d = StSettle;
                end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
                    out_result_d  = '0;
                    out_timeout_d = 1'b1;
                    out_valid_d   = 1'b1;
                    state_d       = StAbandon;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    out_result_d  = result_i;
                    out_timeout_d = 1'b0;
                    out_valid_d   = 1'b1;
                    state_d       = StDone;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            StAbandon: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                // Leave only once the late fin arrived and the timeout report is gone.
                if (phase_match && !out_valid_d) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            req_q         <= 1'b0;
            n_q           <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_timeout_q <= 1'b0;
            flush_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            n_q           <= n_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_timeout_q <= out_timeout_d;
            flush_q       <= flush_d;
        end
    end

    assign in_ready    = in_ready_w;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_timeout = out_timeout_q;
    assign busy        = (state_q != StIdle);
    assign req_o       = req_q;
    assign n_o         = n_q;

endmodule

// File: tb/tb_async_req_master.sv
// Directed bench for async_req_master against a behavioural 2-phase Fibonacci responder.
module tb_async_req_master;

    localparam int unsigned W        = 32;
    localparam int          RESP_CYC = 20;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_n;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_timeout;
    logic          busy;
    logic          req_o;
    logic          fin_i;
    logic [W-1:0]  n_o;
    logic [W-1:0]  result_i;

    logic          resp_rst;
    logic          resp_en;
    logic          force_tog;
    logic          req_seen;
    logic          pend;
    int            rcnt;
    logic [W-1:0]  fib_n;

    int            cyc;
    int            n_checks;
    int            n_err;
    int            req_chg_n, req_chg_cyc, fin_chg_cyc, ov_rise_cyc, busy_rise_cyc;
    int            ov_rises, excl_viol;
    logic          req_prev, fin_prev, ov_prev, busy_prev;

    async_req_master #(
        .TIMEOUT(50)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_n       (in_n),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_timeout(out_timeout),
        .busy       (busy),
        .req_o      (req_o),
        .fin_i      (fin_i),
        .n_o        (n_o),
        .result_i   (result_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] fib(input logic [W-1:0] n);
        logic [W-1:0] a, b, c;
        a = 1;
        b = 1;
        for (int i = 1; i < int'(n); i++) begin
            c = a + b;
            a = b;
            b = c;
        end
        return b;
    endfunction

    // Responder: answers each req toggle after RESP_CYC cycles; force_tog injects a bare toggle.
    always @(posedge clk) begin
        if (resp_rst) begin
            fin_i    <= 1'b0;
            req_seen <= 1'b0;
            pend     <= 1'b0;
            rcnt     <= 0;
            result_i <= '0;
        end else begin
            if (force_tog) begin
                fin_i <= ~fin_i;
            end else if (pend) begin
                if (rcnt == 0) begin
                    result_i <= fib(fib_n);
                    fin_i    <= ~fin_i;
                    pend     <= 1'b0;
                end else begin
                    rcnt <= rcnt - 1;
                end
            end
            if (req_o != req_seen) begin
                req_seen <= req_o;
                if (resp_en) begin
                    pend  <= 1'b1;
                    rcnt  <= RESP_CYC - 1;
                    fib_n <= n_o;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (req_o !== req_prev) begin
            req_chg_cyc = cyc;
            req_chg_n++;
        end
        if (fin_i !== fin_prev) fin_chg_cyc = cyc;
        if (out_valid && !ov_prev) begin
            ov_rise_cyc = cyc;
            ov_rises++;
        end
        if (busy && !busy_prev) busy_rise_cyc = cyc;
        if (out_valid && in_ready) excl_viol++;
        req_prev  = req_o;
        fin_prev  = fin_i;
        ov_prev   = out_valid;
        busy_prev = busy;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        resp_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        resp_rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic send(input string tag, input logic [W-1:0] n);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        in_n     = n;
        k = 0;
        while (in_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, output logic [W-1:0] r, output logic t);
        int k;
        k = 0;
        while (out_valid !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 64'(out_valid), 64'(1));
        r = out_result;
        t = out_timeout;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] r;
        logic         t;
        int           base_req, base_ov;

        cyc = 0; n_checks = 0; n_err = 0;
        req_chg_n = 0; req_chg_cyc = 0; fin_chg_cyc = 0; ov_rise_cyc = 0; busy_rise_cyc = 0;
        ov_rises = 0; excl_viol = 0;
        req_prev = 1'b0; fin_prev = 1'b0; ov_prev = 1'b0; busy_prev = 1'b0;
        rst_n = 1'b1; resp_rst = 1'b0; resp_en = 1'b1; force_tog = 1'b0;
        in_valid = 1'b0; in_n = '0; out_ready = 1'b1;

        // Reset values and post-reset synchroniser flush
        @(negedge clk);
        rst_n    = 1'b0;
        resp_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_req", 64'(req_o), 64'(0));
        check_eq("rst_n_o", 64'(n_o), 64'(0));
        check_eq("rst_ovalid", 64'(out_valid), 64'(0));
        check_eq("rst_oresult", 64'(out_result), 64'(0));
        check_eq("rst_otimeout", 64'(out_timeout), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_iready", 64'(in_ready), 64'(0));
        rst_n    = 1'b1;
        resp_rst = 1'b0;
        @(negedge clk);
        check_eq("rst_flush", 64'(in_ready), 64'(0));
        @(negedge clk);
        check_eq("rst_ready", 64'(in_ready), 64'(1));

        // 1: single operand
        base_req = req_chg_n;
        send("t1_acc", 10);
        wait_out("t1_seen", r, t);
        check_eq("t1_result", 64'(r), 64'(89));
        check_eq("t1_timeout", 64'(t), 64'(0));
        check_eq("t1_req_toggles", 64'(req_chg_n - base_req), 64'(1));
        check_eq("t1_req_o", 64'(req_o), 64'(1));
        check_eq("t1_setup_lat", 64'(req_chg_cyc - busy_rise_cyc), 64'(2));
        check_eq("t1_fin_lat", 64'(ov_rise_cyc - fin_chg_cyc), 64'(5));
        check_eq("t1_idle", 64'(busy), 64'(0));

        // 2: back-to-back operands
        do_reset();
        base_req = req_chg_n;
        send("t2a_acc", 44);
        wait_out("t2a_seen", r, t);
        check_eq("t2a_result", 64'(r), 64'(1134903170));
        check_eq("t2a_timeout", 64'(t), 64'(0));
        send("t2b_acc", 5);
        wait_out("t2b_seen", r, t);
        check_eq("t2b_result", 64'(r), 64'(8));
        check_eq("t2_req_toggles", 64'(req_chg_n - base_req), 64'(2));
        check_eq("t2_req_o", 64'(req_o), 64'(0));

        // 3: output back-pressure
        out_ready = 1'b0;
        send("t3_acc", 7);
        for (int k = 0; k < 400 && out_valid !== 1'b1; k++) @(negedge clk);
        check_eq("t3_seen", 64'(out_valid), 64'(1));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_eq("t3_hold_result", 64'(out_result), 64'(21));
            check_eq("t3_hold_iready", 64'(in_ready), 64'(0));
        end
        check_eq("t3_hold_valid", 64'(out_valid), 64'(1));
        check_eq("t3_n_o", 64'(n_o), 64'(7));
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_consumed", 64'(out_valid), 64'(0));

        // 4: silent responder -> timeout, then late fin
        do_reset();
        resp_en = 1'b0;
        base_ov = ov_rises;
        send("t4_acc", 3);
        wait_out("t4_seen", r, t);
        check_eq("t4_timeout", 64'(t), 64'(1));
        check_eq("t4_result", 64'(r), 64'(0));
        check_eq("t4_lat", 64'(ov_rise_cyc - req_chg_cyc), 64'(50));
        check_eq("t4_ovalid_cleared", 64'(out_valid), 64'(0));
        repeat (5) @(negedge clk);
        check_eq("t4_abandon_busy", 64'(busy), 64'(1));
        check_eq("t4_abandon_iready", 64'(in_ready), 64'(0));
        force_tog = 1'b1;
        @(negedge clk);
        force_tog = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t4_late_iready", 64'(in_ready), 64'(1));
        check_eq("t4_late_busy", 64'(busy), 64'(0));
        check_eq("t4_one_ovalid", 64'(ov_rises - base_ov), 64'(1));
        resp_en = 1'b1;

        // 5: reset during WAIT_FIN, responder reset later
        do_reset();
        base_ov = ov_rises;
        send("t5_acc", 3);
        repeat (5) @(negedge clk);
        check_eq("t5_waiting", 64'(busy), 64'(1));
        check_eq("t5_req_pre", 64'(req_o), 64'(1));
        resp_en = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        check_eq("t5_req_rst", 64'(req_o), 64'(0));
        check_eq("t5_ovalid_rst", 64'(out_valid), 64'(0));
        check_eq("t5_idle_rst", 64'(busy), 64'(0));
        for (int k = 0; k < 60 && fin_i !== 1'b1; k++) @(negedge clk);
        check_eq("t5_late_fin", 64'(fin_i), 64'(1));
        repeat (4) @(negedge clk);
        check_eq("t5_blocked", 64'(in_ready), 64'(0));
        check_eq("t5_no_ovalid", 64'(ov_rises - base_ov), 64'(0));
        resp_rst = 1'b1;
        @(negedge clk);
        resp_rst = 1'b0;
        check_eq("t5_sync0", 64'(in_ready), 64'(0));
        @(negedge clk);
        check_eq("t5_sync1", 64'(in_ready), 64'(0));
        @(negedge clk);
        check_eq("t5_ready", 64'(in_ready), 64'(1));
        resp_en = 1'b1;

        // 6: spurious fin toggle while idle
        do_reset();
        base_ov = ov_rises;
        force_tog = 1'b1;
        @(negedge clk);
        force_tog = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        in_n     = 9;
        repeat (5) @(negedge clk);
        check_eq("t6_iready", 64'(in_ready), 64'(0));
        check_eq("t6_busy", 64'(busy), 64'(0));
        check_eq("t6_no_ovalid", 64'(ov_rises - base_ov), 64'(0));
        in_valid  = 1'b0;
        force_tog = 1'b1;
        @(negedge clk);
        force_tog = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t6_recover", 64'(in_ready), 64'(1));

        check_eq("excl_ovalid_iready", 64'(excl_viol), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
